// File: rtl/greenhouse_zone_controller.sv
// Per-zone climate controller: fan with persistence and hysteresis, irrigation
// FSM (IDLE/WATER/SOAK) with timeout, humidity band control and sticky alerts.
module greenhouse_zone_controller #(
  parameter int W       = 8,
  parameter int ZONES   = 4,
  parameter int PERSIST = 4,
  parameter int HYST    = 2,
  parameter int T_HI    = 40,
  parameter int T_ALERT = 45,
  parameter int SOIL_LO = 30,
  parameter int HUM_LO  = 40,
  parameter int HUM_HI  = 70,
  parameter int IRR_MAX = 16,
  parameter int SOAK    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sample_valid,
  input  logic [ZONES*W-1:0]   temperature,
  input  logic [ZONES*W-1:0]   soil_moisture,
  input  logic [ZONES*W-1:0]   humidity,
  input  logic [2*ZONES-1:0]   mode_fan,
  input  logic [2*ZONES-1:0]   mode_irr,
  input  logic                 alert_ack,
  output logic [ZONES-1:0]     fan,
  output logic [ZONES-1:0]     irrigation,
  output logic [ZONES-1:0]     humidity_control,
  output logic [ZONES-1:0]     alert,
  output logic                 alert_any
);

  localparam int CW   = $clog2(PERSIST + 1);
  localparam int TMAX = (IRR_MAX > SOAK) ? IRR_MAX : SOAK;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WATER = 2'd1;
  localparam logic [1:0] ST_SOAK  = 2'd2;

  localparam logic [1:0] MODE_OFF = 2'b01;
  localparam logic [1:0] MODE_ON  = 2'b10;

  localparam logic [W-1:0] TH_FAN_ON  = W'(T_HI);
  localparam logic [W-1:0] TH_FAN_OFF = W'(T_HI - HYST);
  localparam logic [W-1:0] TH_ALERT   = W'(T_ALERT);
  localparam logic [W-1:0] SOIL_START = W'(SOIL_LO);
  localparam logic [W-1:0] SOIL_STOP  = W'(SOIL_LO + HYST);
  localparam logic [W-1:0] SOIL_ALERT = W'(SOIL_LO - HYST);
  localparam logic [W-1:0] HUM_LO_W   = W'(HUM_LO);
  localparam logic [W-1:0] HUM_HI_W   = W'(HUM_HI);
  localparam logic [W-1:0] HUM_CLR_LO = W'(HUM_LO + HYST);
  localparam logic [W-1:0] HUM_CLR_HI = W'(HUM_HI - HYST);
  localparam logic [W-1:0] HUM_ALERT  = W'(HUM_LO - HYST);

  localparam logic [CW-1:0] PERSIST_C = CW'(PERSIST);
  localparam logic [TW-1:0] IRR_LAST  = TW'(IRR_MAX - 1);
  localparam logic [TW-1:0] SOAK_LAST = TW'(SOAK - 1);

  generate
    if (T_HI < HYST || SOIL_LO < HYST || HUM_LO < HYST ||
        HUM_HI > ((1 << W) - 1 - HYST) || IRR_MAX < 1 || SOAK < 1 || PERSIST < 1) begin : g_bad_params
      $error("greenhouse_zone_controller: illegal parameter combination");
    end
  endgenerate

  logic [ZONES-1:0] alert_vec_d;
  logic             alert_any_q;

  genvar gi;
  generate
    for (gi = 0; gi < ZONES; gi++) begin : g_zone
      logic [W-1:0]  temp_z, soil_z, hum_z;
      logic [1:0]    mf, mi;
      logic          fan_auto_q, fan_auto_d;
      logic [CW-1:0] on_cnt_q, on_cnt_d, off_cnt_q, off_cnt_d;
      logic [CW-1:0] on_inc, off_inc;
      logic          fan_q, fan_d;
      logic [1:0]    irr_st_q, irr_st_d;
      logic [TW-1:0] tmr_q, tmr_d;
      logic          irr_q, irr_d;
      logic          hum_q, hum_d;
      logic          alert_q, alert_d;
      logic          timeout;
      logic          set_cond;

      assign temp_z = temperature[gi*W +: W];
      assign soil_z = soil_moisture[gi*W +: W];
      assign hum_z  = humidity[gi*W +: W];
      assign mf     = mode_fan[2*gi +: 2];
      assign mi     = mode_irr[2*gi +: 2];

      assign on_inc  = (on_cnt_q == PERSIST_C) ? PERSIST_C : on_cnt_q + 1'b1;
      assign off_inc = (off_cnt_q == PERSIST_C) ? PERSIST_C : off_cnt_q + 1'b1;

      always_comb begin
        fan_auto_d = fan_auto_q;
        on_cnt_d   = on_cnt_q;
        off_cnt_d  = off_cnt_q;
        irr_st_d   = irr_st_q;
        tmr_d      = tmr_q;
        hum_d      = hum_q;
        alert_d    = alert_q;
        timeout    = 1'b0;

        // Auto fan state keeps tracking even while the output is forced.
        if (sample_valid) begin
          if (!fan_auto_q) begin
            off_cnt_d = '0;
            on_cnt_d  = (temp_z > TH_FAN_ON) ? on_inc : '0;
            if (on_cnt_d == PERSIST_C) begin
              fan_auto_d = 1'b1;
              on_cnt_d   = '0;
            end
          end else begin
            on_cnt_d  = '0;
            off_cnt_d = (temp_z < TH_FAN_OFF) ? off_inc : '0;
            if (off_cnt_d == PERSIST_C) begin
              fan_auto_d = 1'b0;
              off_cnt_d  = '0;
            end
          end
        end

        // Forced irrigation parks the FSM in IDLE without waiting for a sample.
        if (mi == MODE_OFF || mi == MODE_ON) begin
          irr_st_d = ST_IDLE;
          tmr_d    = '0;
        end else if (sample_valid) begin
          case (irr_st_q)
            ST_IDLE: begin
              if (soil_z < SOIL_START) begin
                irr_st_d = ST_WATER;
                tmr_d    = '0;
              end
            end
            ST_WATER: begin
              if (soil_z >= SOIL_STOP) begin
                irr_st_d = ST_SOAK;
                tmr_d    = '0;
              end else if (tmr_q == IRR_LAST) begin
                irr_st_d = ST_SOAK;
                tmr_d    = '0;
                timeout  = 1'b1;
              end else begin
                tmr_d = tmr_q + 1'b1;
              end
            end
            ST_SOAK: begin
              if (tmr_q == SOAK_LAST) begin
                irr_st_d = ST_IDLE;
                tmr_d    = '0;
              end else begin
                tmr_d = tmr_q + 1'b1;
              end
            end
            default: begin
              irr_st_d = ST_IDLE;
              tmr_d    = '0;
            end
          endcase
        end

        if (sample_valid) begin
          if (hum_z < HUM_LO_W || hum_z > HUM_HI_W) begin
            hum_d = 1'b1;
          end else if (hum_z >= HUM_CLR_LO && hum_z <= HUM_CLR_HI) begin
            hum_d = 1'b0;
          end
        end

        set_cond = (temp_z > TH_ALERT) || (soil_z < SOIL_ALERT) ||
                   (hum_z < HUM_ALERT) || timeout;
        if (sample_valid && set_cond) begin
          alert_d = 1'b1;
        end else if (alert_ack && !set_cond) begin
          alert_d = 1'b0;
        end

        if (mf == MODE_ON) begin
          fan_d = 1'b1;
        end else if (mf == MODE_OFF) begin
          fan_d = 1'b0;
        end else begin
          fan_d = fan_auto_d;
        end
        irr_d = (mi == MODE_ON) || (irr_st_d == ST_WATER);
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          fan_auto_q <= 1'b0;
          on_cnt_q   <= '0;
          off_cnt_q  <= '0;
          fan_q      <= 1'b0;
          irr_st_q   <= ST_IDLE;
          tmr_q      <= '0;
          irr_q      <= 1'b0;
          hum_q      <= 1'b0;
          alert_q    <= 1'b0;
        end else begin
          fan_auto_q <= fan_auto_d;
          on_cnt_q   <= on_cnt_d;
          off_cnt_q  <= off_cnt_d;
          fan_q      <= fan_d;
          irr_st_q   <= irr_st_d;
          tmr_q      <= tmr_d;
          irr_q      <= irr_d;
          hum_q      <= hum_d;
          alert_q    <= alert_d;
        end
      end

      assign fan[gi]              = fan_q;
      assign irrigation[gi]       = irr_q;
      assign humidity_control[gi] = hum_q;
      assign alert[gi]            = alert_q;
      assign alert_vec_d[gi]      = alert_d;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alert_any_q <= 1'b0;
    end else begin
      alert_any_q <= |alert_vec_d;
    end
  end

  assign alert_any = alert_any_q;

endmodule

// File: tb/tb_greenhouse_zone_controller.sv
// Directed bench for greenhouse_zone_controller: zone 0 is exercised, the
// other zones sit at benign readings so their outputs must stay low.
module tb_greenhouse_zone_controller;

  logic        clk;
  logic        rst_n;
  logic        sample_valid;
  logic [31:0] temperature;
  logic [31:0] soil_moisture;
  logic [31:0] humidity;
  logic [7:0]  mode_fan;
  logic [7:0]  mode_irr;
  logic        alert_ack;
  logic [3:0]  fan;
  logic [3:0]  irrigation;
  logic [3:0]  humidity_control;
  logic [3:0]  alert;
  logic        alert_any;

  int total = 0;
  int bad   = 0;

  greenhouse_zone_controller dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .sample_valid     (sample_valid),
    .temperature      (temperature),
    .soil_moisture    (soil_moisture),
    .humidity         (humidity),
    .mode_fan         (mode_fan),
    .mode_irr         (mode_irr),
    .alert_ack        (alert_ack),
    .fan              (fan),
    .irrigation       (irrigation),
    .humidity_control (humidity_control),
    .alert            (alert),
    .alert_any        (alert_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; applies zone-0 readings for one clock.
  task automatic step(input logic v, input logic ack,
                      input logic [7:0] t, input logic [7:0] s, input logic [7:0] h);
    temperature   = {8'd30, 8'd30, 8'd30, t};
    soil_moisture = {8'd50, 8'd50, 8'd50, s};
    humidity      = {8'd50, 8'd50, 8'd50, h};
    sample_valid  = v;
    alert_ack     = ack;
    @(negedge clk);
    sample_valid  = 1'b0;
    alert_ack     = 1'b0;
    $display("step v=%0b ack=%0b t=%0d s=%0d h=%0d -> fan=%b irr=%b hc=%b alert=%b any=%b",
             v, ack, t, s, h, fan, irrigation, humidity_control, alert, alert_any);
  endtask

  initial begin
    rst_n         = 1'b1;
    sample_valid  = 1'b0;
    alert_ack     = 1'b0;
    mode_fan      = '0;
    mode_irr      = '0;
    temperature   = {4{8'd30}};
    soil_moisture = {4{8'd50}};
    humidity      = {4{8'd50}};

    #1 rst_n = 1'b0;
    #1 chk("reset_outputs", {fan, irrigation, humidity_control, alert, alert_any}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 30, 50, 50);
    chk("post_reset_idle", {fan, irrigation, humidity_control, alert, alert_any}, 32'h0);

    // Fan persistence: three hot samples then a miss must not switch.
    repeat (3) step(1, 0, 41, 50, 50);
    chk("fan_3_hot", fan, 4'b0000);
    step(1, 0, 39, 50, 50);
    chk("fan_after_miss", fan, 4'b0000);
    repeat (3) step(1, 0, 41, 50, 50);
    chk("fan_count_restarted", fan, 4'b0000);
    step(1, 0, 41, 50, 50);
    chk("fan_on_4th", fan, 4'b0001);
    step(0, 0, 30, 50, 50);
    chk("fan_hold_no_valid", fan, 4'b0001);

    // Off path: 39 lies inside the hysteresis band, 37 is below it.
    repeat (4) step(1, 0, 39, 50, 50);
    chk("fan_band_hold", fan, 4'b0001);
    repeat (3) step(1, 0, 37, 50, 50);
    chk("fan_off_3_cool", fan, 4'b0001);
    step(1, 0, 37, 50, 50);
    chk("fan_off_4th", fan, 4'b0000);

    // Fan modes act without a sample; auto state tracks underneath.
    mode_fan = 8'b0000_0010;
    step(0, 0, 30, 50, 50);
    chk("fan_force_on", fan, 4'b0001);
    mode_fan = 8'b0000_0001;
    repeat (4) step(1, 0, 41, 50, 50);
    chk("fan_force_off", fan, 4'b0000);
    mode_fan = 8'b0000_0000;
    step(0, 0, 30, 50, 50);
    chk("fan_auto_tracked", fan, 4'b0001);
    repeat (4) step(1, 0, 37, 50, 50);
    chk("fan_auto_off", fan, 4'b0000);

    // Humidity band control with hysteresis.
    step(1, 0, 30, 50, 39);
    chk("hum_low_set", {humidity_control, alert}, {4'b0001, 4'b0000});
    step(1, 0, 30, 50, 41);
    chk("hum_low_hold", humidity_control, 4'b0001);
    step(1, 0, 30, 50, 50);
    chk("hum_clear", humidity_control, 4'b0000);
    step(1, 0, 30, 50, 75);
    chk("hum_high_set", humidity_control, 4'b0001);
    step(1, 0, 30, 50, 69);
    chk("hum_high_hold", humidity_control, 4'b0001);
    step(1, 0, 30, 50, 68);
    chk("hum_edge_clear", humidity_control, 4'b0000);

    // Alerts: sticky, ack blocked while the condition persists, set beats ack.
    step(1, 0, 50, 50, 50);
    chk("alert_temp_set", {alert, 3'b000, alert_any}, {4'b0001, 4'b0001});
    step(0, 1, 50, 50, 50);
    chk("alert_ack_blocked", {alert, 3'b000, alert_any}, {4'b0001, 4'b0001});
    step(0, 1, 30, 50, 50);
    chk("alert_ack_clear", {alert, 3'b000, alert_any}, {4'b0000, 4'b0000});
    step(1, 1, 46, 50, 50);
    chk("alert_set_wins", {alert, 3'b000, alert_any}, {4'b0001, 4'b0001});
    step(0, 1, 30, 50, 50);
    chk("alert_clear_again", alert, 4'b0000);

    // Dry soil: 16 watering samples, timeout, 8 soak samples, water again.
    step(1, 0, 30, 20, 50);
    chk("irr_start", {irrigation, alert}, {4'b0001, 4'b0001});
    repeat (15) step(1, 0, 30, 20, 50);
    chk("irr_16th", irrigation, 4'b0001);
    step(1, 0, 30, 20, 50);
    chk("irr_timeout_soak", {irrigation, alert}, {4'b0000, 4'b0001});
    repeat (7) step(1, 0, 30, 20, 50);
    chk("irr_soak_7", irrigation, 4'b0000);
    step(1, 0, 30, 20, 50);
    chk("irr_soak_end_idle", irrigation, 4'b0000);
    step(1, 0, 30, 20, 50);
    chk("irr_water_again", irrigation, 4'b0001);
    mode_irr = 8'b0000_0001;
    step(0, 1, 30, 50, 50);
    chk("irr_force_off_ack", {irrigation, alert}, {4'b0000, 4'b0000});
    mode_irr = 8'b0000_0000;

    // Soil 29 waters without tripping the low-moisture alert (29 >= 28).
    repeat (4) step(1, 0, 30, 29, 50);
    chk("irr_wet_start", {irrigation, alert}, {4'b0001, 4'b0000});
    step(1, 0, 30, 32, 50);
    chk("irr_moist_stop", {irrigation, alert, 3'b000, alert_any}, {4'b0000, 4'b0000, 4'b0000});
    repeat (8) step(1, 0, 30, 50, 50);
    chk("irr_soak_done", irrigation, 4'b0000);
    repeat (2) step(1, 0, 30, 29, 50);
    chk("irr_rewater", irrigation, 4'b0001);
    mode_irr = 8'b0000_0001;
    step(0, 0, 30, 29, 50);
    chk("irr_force_off_mid", irrigation, 4'b0000);
    mode_irr = 8'b0000_0000;
    step(0, 0, 30, 29, 50);
    chk("irr_auto_idle_hold", irrigation, 4'b0000);
    step(1, 0, 30, 29, 50);
    chk("irr_resume_idle", irrigation, 4'b0001);
    mode_irr = 8'b0000_0010;
    repeat (20) step(1, 0, 30, 29, 50);
    chk("irr_force_on_no_timeout", {irrigation, alert}, {4'b0001, 4'b0000});
    mode_irr = 8'b0000_0000;
    step(1, 0, 30, 29, 50);
    chk("irr_auto_after_force", irrigation, 4'b0001);

    // Asynchronous reset mid-WATER with the fan forced on.
    mode_fan = 8'b0000_0010;
    step(0, 0, 30, 29, 50);
    chk("pre_reset_drive", {fan, irrigation}, {4'b0001, 4'b0001});
    #2 rst_n = 1'b0;
    #1 chk("async_reset", {fan, irrigation, humidity_control, alert, alert_any}, 32'h0);
    mode_fan = 8'b0000_0000;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) step(0, 0, 30, 20, 50);
    chk("release_no_valid", {fan, irrigation, humidity_control, alert, alert_any}, 32'h0);
    step(1, 0, 30, 20, 50);
    chk("first_valid_after_reset", {irrigation, alert}, {4'b0001, 4'b0001});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
